gshare_ongorucu: RTL and testbench
==================================

// Module: gshare_ongorucu
// PURPOSE
//  Parametrised successor to the 2-bit-table branch predictor: gshare direction predictor plus tagged BTB.
//  Gives a same-cycle prediction for the fetch stage and trains in one cycle from execute-stage resolution.
//  Reset-time table clearing is done by a sweep FSM; hazir flags when predictions are valid.
// PARAMETERS
//  PS_UZ        32    PC / target width
//  PHT_DERINLIK 1024  pattern history table entries (power of 2)
//  GECMIS_UZ    10    global history bits (<= log2(PHT_DERINLIK))
//  SAYAC_UZ     2     saturating counter width (>= 2)
//  BTB_DERINLIK 64    direct-mapped BTB entries (power of 2)
// PORTS
//  clk              in   1      clock
//  rst              in   1      asynchronous active-low reset
//  getir_ps         in   PS_UZ  fetch PC
//  getir_buyruk     in   32     fetch instruction
//  getir_gecerli    in   1      fetch request valid
//  yurut_ps         in   PS_UZ  resolved branch PC
//  yurut_buyruk     in   32     resolved branch instruction
//  yurut_dallan     in   1      resolved direction (1 = taken)
//  yurut_dallan_ps  in   PS_UZ  resolved target
//  yurut_gecerli    in   1      resolution valid, train this cycle
//  sonuc_dallan     out  1      predicted taken
//  sonuc_dallan_ps  out  PS_UZ  predicted next PC
//  hazir            out  1      tables initialised, predictions are meaningful
// BEHAVIOUR
//  Index: pi = ps[2 +: log2 PHT] ^ zero-extended GHR. BTB index bi = ps[2 +: log2 BTB]; tag = ps[PS_UZ-1 : 2+log2 BTB].
//  Class from opcode [6:0]: KOSUL 1100011 (conditional), JAL 1101111, anything else is not a branch.
//  Prediction is combinational from current state, zero latency:
//   KOSUL: taken = PHT[pi] MSB & BTB hit. JAL: taken = BTB hit. Non-branch or no hit: taken = 0.
//   sonuc_dallan_ps = taken ? BTB target : getir_ps + 4 (mod 2^PS_UZ).
//   Outputs are gated by getir_gecerli & hazir; when the gate is low: sonuc_dallan = 0, sonuc_dallan_ps = getir_ps + 4.
//  Training at posedge when yurut_gecerli & hazir:
//   KOSUL: PHT[pi(yurut_ps, GHR)] saturating +1 if taken, -1 if not (clamps at 0 and 2^SAYAC_UZ-1).
//   KOSUL: GHR <= {GHR[GECMIS_UZ-2:0], yurut_dallan}.
//   KOSUL or JAL taken: BTB[bi] <= {valid = 1, tag, yurut_dallan_ps}, overwriting the entry.
//   Non-branch: no state change.
//  GHR is updated only at resolution (non-speculative). At most one branch is in flight between fetch and resolve.
//  Same-cycle fetch and train: the prediction sees pre-edge state, and the update is visible from the next cycle.
//  FSM: BASLAT -> CALIS.
//   BASLAT: pointer p counts 0..N-1, N = max(PHT, BTB). Each cycle: PHT[p] <= 2^(SAYAC_UZ-1)-1 if p < PHT; BTB valid[p] <= 0 if p < BTB.
//   BASLAT: training is ignored. At p == N-1, go to CALIS. hazir = (state == CALIS), rising N cycles after rst release.
//  Reset, including mid-sweep or mid-run: async to BASLAT, p = 0, GHR = 0, hazir = 0; arrays are cleared by the new sweep.
// CONFIGURATION
//  GSHARE_ISTATISTIK_EN defined: extra outputs istat_toplam[31:0] and istat_yanlis[31:0].
//   istat_toplam counts trained KOSUL/JAL resolutions.
//   istat_yanlis counts mispredictions: re-evaluated prediction at yurut_ps != yurut_dallan, or taken and target != yurut_dallan_ps.
//   Both counters saturate at 32'hFFFFFFFF and clear on reset.
//  Undefined: the ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package gshare_pkg: opcode constants, KOSUL/JAL/NONE class enum, FSM state enum, clog2-based index/tag width constants.
//  Sub-module gshare_btb: tagged direct-mapped BTB with lookup port, write port and sweep-clear port.
//  PHT, GHR, FSM and stats stay in the top level.
// TESTING
//  Reset release, defaults: count cycles until hazir = 1 -> 1024; during sweep sonuc_dallan = 0 and sonuc_dallan_ps = getir_ps + 4.
//  Cold BTB: KOSUL at 0x100 fetched -> not taken, 0x104. Train taken to 0x80 twice, then fetch with the same GHR -> taken, 0x80.
//  Saturation: 5 not-taken trains at one index -> counter is 0; 1 taken -> counter is 1 and predicts not taken.
//  History: alternating T/N trains at 0x200 -> after warm-up, GHR-distinguished entries predict the alternation with 0 mispredicts.
//  BTB alias: JAL at 0x40 taken to 0x400, then JAL at 0x140 (same bi, different tag) -> 0x40 misses and predicts 0x44.
//  Reset mid-sweep at cycle 500, release -> hazir returns exactly 1024 cycles later; stats (macro on) read 0.

Source files
------------

// File: rtl/gshare_pkg.sv
// ---------------------------------------------------------------------------
// gshare_pkg
//   Shared definitions for the gshare direction predictor and its BTB:
//   opcode constants, branch class and FSM state enums, default sizes and
//   small helper functions for decoding and width derivation.
//   Used by gshare_btb and gshare_ongorucu via import gshare_pkg::*.
// ---------------------------------------------------------------------------
package gshare_pkg;

    localparam logic [6:0] OP_KOSUL = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam int VARS_PS_UZ   = 32;
    localparam int VARS_PHT     = 1024;
    localparam int VARS_GECMIS  = 10;
    localparam int VARS_SAYAC   = 2;
    localparam int VARS_BTB     = 64;

    typedef enum logic [1:0] {SINIF_YOK, SINIF_KOSUL, SINIF_JAL} sinif_t;
    typedef enum logic       {BASLAT, CALIS} durum_t;

    function automatic sinif_t sinif_bul(input logic [6:0] op);
        case (op)
            OP_KOSUL: return SINIF_KOSUL;
            OP_JAL:   return SINIF_JAL;
            default:  return SINIF_YOK;
        endcase
    endfunction

    // Direction decision shared by the fetch-side prediction and the
    // execute-side re-evaluation used for misprediction accounting.
    function automatic logic tahmin_et(input sinif_t s, input logic msb, input logic isabet);
        case (s)
            SINIF_KOSUL: return msb & isabet;
            SINIF_JAL:   return isabet;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic int etiket_uz(input int ps_uz, input int btb_derinlik);
        return ps_uz - 2 - $clog2(btb_derinlik);
    endfunction

    function automatic int enb(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gshare_btb.sv
// ---------------------------------------------------------------------------
// gshare_btb
//   Tagged, direct-mapped branch target buffer. Storage carries no reset;
//   the owner clears valid bits one index per cycle through the sweep port.
// Ports
//   clk          clock
//   i_ara_ps     NRD lookup PCs (packed array, one per read lane)
//   o_isabet     per-lane hit (valid and tag match)
//   o_hedef      per-lane stored target
//   i_yaz        write enable: install {valid, tag(i_yaz_ps), i_yaz_hedef}
//   i_yaz_ps     PC being installed
//   i_yaz_hedef  target being installed
//   i_sil        sweep clear enable (wins over a write)
//   i_sil_idx    index whose valid bit is cleared
// ---------------------------------------------------------------------------
module gshare_btb
    import gshare_pkg::*;
#(
    parameter int PS_UZ    = VARS_PS_UZ,
    parameter int DERINLIK = VARS_BTB,
    parameter int NRD      = 1
) (
    input  logic                           clk,
    input  logic [NRD-1:0][PS_UZ-1:0]      i_ara_ps,
    output logic [NRD-1:0]                 o_isabet,
    output logic [NRD-1:0][PS_UZ-1:0]      o_hedef,
    input  logic                           i_yaz,
    input  logic [PS_UZ-1:0]               i_yaz_ps,
    input  logic [PS_UZ-1:0]               i_yaz_hedef,
    input  logic                           i_sil,
    input  logic [$clog2(DERINLIK)-1:0]    i_sil_idx
);

    localparam int IDX = $clog2(DERINLIK);
    localparam int TAG = etiket_uz(PS_UZ, DERINLIK);

    logic             r_gecerli [DERINLIK];
    logic [TAG-1:0]   r_etiket  [DERINLIK];
    logic [PS_UZ-1:0] r_hedef   [DERINLIK];

    logic [IDX-1:0]   w_yaz_idx;
    logic [1:0]       w_unused_yaz;

    assign w_yaz_idx    = i_yaz_ps[2 +: IDX];
    assign w_unused_yaz = i_yaz_ps[1:0];

    always_ff @(posedge clk) begin
        if (i_sil) begin
            r_gecerli[i_sil_idx] <= 1'b0;
        end else if (i_yaz) begin
            r_gecerli[w_yaz_idx] <= 1'b1;
            r_etiket[w_yaz_idx]  <= i_yaz_ps[PS_UZ-1 -: TAG];
            r_hedef[w_yaz_idx]   <= i_yaz_hedef;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_ara
        logic [IDX-1:0] w_idx;
        logic [1:0]     w_unused_alt;
        assign w_idx        = i_ara_ps[g][2 +: IDX];
        assign w_unused_alt = i_ara_ps[g][1:0];
        assign o_isabet[g]  = r_gecerli[w_idx] && (r_etiket[w_idx] == i_ara_ps[g][PS_UZ-1 -: TAG]);
        assign o_hedef[g]   = r_hedef[w_idx];
    end

endmodule

// File: rtl/gshare_ongorucu.sv
// ---------------------------------------------------------------------------
// gshare_ongorucu
//   gshare direction predictor (PHT indexed by PC ^ global history) with a
//   tagged BTB. Same-cycle prediction for fetch, single-cycle training from
//   execute. After reset a sweep FSM initialises the tables; hazir rises
//   when predictions become meaningful.
//   Optional statistics: define GSHARE_ISTATISTIK_EN.
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   getir_ps/buyruk     fetch PC and instruction, getir_gecerli valid
//   yurut_ps/buyruk     resolved branch PC and instruction
//   yurut_dallan(_ps)   resolved direction and target, yurut_gecerli trains
//   sonuc_dallan(_ps)   predicted taken and next PC
//   hazir               tables initialised
//   istat_toplam        (GSHARE_ISTATISTIK_EN) trained branch resolutions
//   istat_yanlis        (GSHARE_ISTATISTIK_EN) mispredictions among them
// ---------------------------------------------------------------------------
module gshare_ongorucu
    import gshare_pkg::*;
#(
    parameter int PS_UZ        = VARS_PS_UZ,
    parameter int PHT_DERINLIK = VARS_PHT,
    parameter int GECMIS_UZ    = VARS_GECMIS,
    parameter int SAYAC_UZ     = VARS_SAYAC,
    parameter int BTB_DERINLIK = VARS_BTB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PS_UZ-1:0] getir_ps,
    input  logic [31:0]      getir_buyruk,
    input  logic             getir_gecerli,
    input  logic [PS_UZ-1:0] yurut_ps,
    input  logic [31:0]      yurut_buyruk,
    input  logic             yurut_dallan,
    input  logic [PS_UZ-1:0] yurut_dallan_ps,
    input  logic             yurut_gecerli,
    output logic             sonuc_dallan,
    output logic [PS_UZ-1:0] sonuc_dallan_ps,
    output logic             hazir
`ifdef GSHARE_ISTATISTIK_EN
    ,
    output logic [31:0]      istat_toplam,
    output logic [31:0]      istat_yanlis
`endif
);

    localparam int PHT_IDX = $clog2(PHT_DERINLIK);
    localparam int BTB_IDX = $clog2(BTB_DERINLIK);
    localparam int N       = enb(PHT_DERINLIK, BTB_DERINLIK);
    localparam int P_UZ    = $clog2(N);
    localparam logic [SAYAC_UZ-1:0] SAYAC_ILK = {1'b0, {(SAYAC_UZ-1){1'b1}}};
`ifdef GSHARE_ISTATISTIK_EN
    localparam int NRD = 2;   // lane 1 re-evaluates the prediction at yurut_ps
`else
    localparam int NRD = 1;
`endif

    durum_t                     r_durum, w_durum_sonraki;
    logic [P_UZ-1:0]            r_p;
    logic [GECMIS_UZ-1:0]       r_ghr;
    logic [SAYAC_UZ-1:0]        r_pht [PHT_DERINLIK];

    logic                       w_hazir, w_sil, w_egit, w_egit_kosul, w_btb_yaz, w_tahmin;
    sinif_t                     w_getir_sinif, w_yurut_sinif;
    logic [PHT_IDX-1:0]         w_getir_pi, w_yurut_pi;
    logic [SAYAC_UZ-1:0]        w_pht_eski, w_pht_yeni;
    logic [NRD-1:0][PS_UZ-1:0]  w_ara_ps, w_hedef;
    logic [NRD-1:0]             w_isabet;
    logic                       w_unused_bitler;

    assign w_unused_bitler = ^{getir_buyruk[31:7], yurut_buyruk[31:7]};

    assign w_hazir       = (r_durum == CALIS);
    assign w_sil         = (r_durum == BASLAT);
    assign w_getir_sinif = sinif_bul(getir_buyruk[6:0]);
    assign w_yurut_sinif = sinif_bul(yurut_buyruk[6:0]);
    assign w_getir_pi    = getir_ps[2 +: PHT_IDX] ^ PHT_IDX'(r_ghr);
    assign w_yurut_pi    = yurut_ps[2 +: PHT_IDX] ^ PHT_IDX'(r_ghr);

    assign w_egit        = yurut_gecerli & w_hazir;
    assign w_egit_kosul  = w_egit & (w_yurut_sinif == SINIF_KOSUL);
    assign w_btb_yaz     = w_egit & (w_yurut_sinif != SINIF_YOK) & yurut_dallan;

    assign w_ara_ps[0] = getir_ps;
`ifdef GSHARE_ISTATISTIK_EN
    assign w_ara_ps[1] = yurut_ps;
`endif

    gshare_btb #(
        .PS_UZ    (PS_UZ),
        .DERINLIK (BTB_DERINLIK),
        .NRD      (NRD)
    ) u_btb (
        .clk         (clk),
        .i_ara_ps    (w_ara_ps),
        .o_isabet    (w_isabet),
        .o_hedef     (w_hedef),
        .i_yaz       (w_btb_yaz),
        .i_yaz_ps    (yurut_ps),
        .i_yaz_hedef (yurut_dallan_ps),
        .i_sil       (w_sil && (32'(r_p) < BTB_DERINLIK)),
        .i_sil_idx   (r_p[BTB_IDX-1:0])
    );

    // Prediction: purely combinational on pre-edge state.
    assign w_tahmin        = getir_gecerli & w_hazir &
                             tahmin_et(w_getir_sinif, r_pht[w_getir_pi][SAYAC_UZ-1], w_isabet[0]);
    assign sonuc_dallan    = w_tahmin;
    assign sonuc_dallan_ps = w_tahmin ? w_hedef[0] : getir_ps + PS_UZ'(4);
    assign hazir           = w_hazir;

    // Saturating counter step for the trained entry.
    assign w_pht_eski = r_pht[w_yurut_pi];
    always_comb begin
        w_pht_yeni = w_pht_eski;
        if (yurut_dallan && (w_pht_eski != '1))
            w_pht_yeni = w_pht_eski + SAYAC_UZ'(1);
        else if (!yurut_dallan && (w_pht_eski != '0))
            w_pht_yeni = w_pht_eski - SAYAC_UZ'(1);
    end

    // Table contents are not reset; the sweep rewrites every entry.
    always_ff @(posedge clk) begin
        if (w_sil && (32'(r_p) < PHT_DERINLIK))
            r_pht[r_p[PHT_IDX-1:0]] <= SAYAC_ILK;
        else if (w_egit_kosul)
            r_pht[w_yurut_pi] <= w_pht_yeni;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_durum <= BASLAT;
            r_p     <= '0;
            r_ghr   <= '0;
        end else begin
            r_durum <= w_durum_sonraki;
            if (w_sil)
                r_p <= r_p + P_UZ'(1);
            if (w_egit_kosul)
                r_ghr <= {r_ghr[GECMIS_UZ-2:0], yurut_dallan};
        end
    end

    always_comb begin
        w_durum_sonraki = r_durum;
        if (r_durum == BASLAT && r_p == P_UZ'(N-1))
            w_durum_sonraki = CALIS;
    end

`ifdef GSHARE_ISTATISTIK_EN
    logic        w_y_tahmin, w_yanlis, w_say;
    logic [31:0] r_toplam, r_yanlis;

    assign w_y_tahmin = tahmin_et(w_yurut_sinif, w_pht_eski[SAYAC_UZ-1], w_isabet[1]);
    assign w_yanlis   = (w_y_tahmin != yurut_dallan) |
                        (w_y_tahmin & (w_hedef[1] != yurut_dallan_ps));
    assign w_say      = w_egit & (w_yurut_sinif != SINIF_YOK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_toplam <= '0;
            r_yanlis <= '0;
        end else if (w_say) begin
            if (r_toplam != '1)
                r_toplam <= r_toplam + 32'd1;
            if (w_yanlis && (r_yanlis != '1))
                r_yanlis <= r_yanlis + 32'd1;
        end
    end

    assign istat_toplam = r_toplam;
    assign istat_yanlis = r_yanlis;
`endif

endmodule

// File: tb/tb_gshare_ongorucu.sv
// ---------------------------------------------------------------------------
// tb_gshare_ongorucu
//   Directed bench for gshare_ongorucu with default parameters. Expected
//   values are worked out by hand from PC, history and counter state.
//   Statistics checks are included when GSHARE_ISTATISTIK_EN is defined.
// ---------------------------------------------------------------------------
module tb_gshare_ongorucu;

    localparam logic [31:0] KOSUL = 32'h0000_0063;
    localparam logic [31:0] JAL   = 32'h0000_006F;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] getir_ps, getir_buyruk, yurut_ps, yurut_buyruk, yurut_dallan_ps;
    logic        getir_gecerli, yurut_dallan, yurut_gecerli;
    logic        sonuc_dallan, hazir;
    logic [31:0] sonuc_dallan_ps;
`ifdef GSHARE_ISTATISTIK_EN
    logic [31:0] istat_toplam, istat_yanlis;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gshare_ongorucu dut (
        .clk             (clk),
        .rst             (rst),
        .getir_ps        (getir_ps),
        .getir_buyruk    (getir_buyruk),
        .getir_gecerli   (getir_gecerli),
        .yurut_ps        (yurut_ps),
        .yurut_buyruk    (yurut_buyruk),
        .yurut_dallan    (yurut_dallan),
        .yurut_dallan_ps (yurut_dallan_ps),
        .yurut_gecerli   (yurut_gecerli),
        .sonuc_dallan    (sonuc_dallan),
        .sonuc_dallan_ps (sonuc_dallan_ps),
        .hazir           (hazir)
`ifdef GSHARE_ISTATISTIK_EN
        ,
        .istat_toplam    (istat_toplam),
        .istat_yanlis    (istat_yanlis)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tahmin_kontrol(input string tag, input logic exp_d, input logic [31:0] exp_ps);
        chk({tag, "_dallan"}, 32'(sonuc_dallan), 32'(exp_d));
        chk({tag, "_ps"}, sonuc_dallan_ps, exp_ps);
    endtask

    task automatic getir(input logic [31:0] ps, input logic [31:0] buyruk);
        @(negedge clk);
        getir_ps      = ps;
        getir_buyruk  = buyruk;
        getir_gecerli = 1'b1;
        #1;
    endtask

    task automatic egit(input logic [31:0] ps, input logic [31:0] buyruk,
                        input logic d, input logic [31:0] hedef);
        @(negedge clk);
        yurut_ps        = ps;
        yurut_buyruk    = buyruk;
        yurut_dallan    = d;
        yurut_dallan_ps = hedef;
        yurut_gecerli   = 1'b1;
        @(posedge clk);
        #1;
        yurut_gecerli   = 1'b0;
    endtask

    task automatic hazir_bekle(output int n);
        n = 0;
        while (!hazir && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic out;

        getir_ps = 32'h100; getir_buyruk = KOSUL; getir_gecerli = 1'b1;
        yurut_ps = '0; yurut_buyruk = NOP; yurut_dallan = 1'b0;
        yurut_dallan_ps = '0; yurut_gecerli = 1'b0;
        #2;
        chk("rst_hazir", 32'(hazir), 32'd0);
        tahmin_kontrol("rst_gate", 1'b0, 32'h104);

        // Initial sweep: gated outputs midway, hazir after exactly 1024 cycles.
        @(negedge clk) rst = 1'b1;
        n = 0;
        while (!hazir && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 500) tahmin_kontrol("sweep500", 1'b0, 32'h104);
        end
        chk("sweep_len", 32'(n), 32'd1024);

        // Cold BTB.
        getir(32'h100, KOSUL);
        tahmin_kontrol("cold", 1'b0, 32'h104);

        // Ten taken trains fill GHR with ones (each at a different index);
        // the entry at 0x40^0x3FF is still weakly not-taken.
        for (int i = 0; i < 10; i++) egit(32'h100, KOSUL, 1'b1, 32'h80);
        getir(32'h100, KOSUL);
        tahmin_kontrol("ghr_full_weak", 1'b0, 32'h104);
        getir(32'h100, JAL);
        tahmin_kontrol("jal_hit", 1'b1, 32'h80);
        egit(32'h100, KOSUL, 1'b1, 32'h80);
        getir(32'h100, KOSUL);
        tahmin_kontrol("taken_once", 1'b1, 32'h80);
        egit(32'h100, KOSUL, 1'b1, 32'h80);
        getir(32'h100, KOSUL);
        tahmin_kontrol("taken_twice", 1'b1, 32'h80);

        // Saturation: PCs chosen so every train lands on PHT[0x3BF].
        // 3 -> 2 -> 1 -> 0 -> 0 -> 0, then taken -> 1.
        egit(32'h100, KOSUL, 1'b0, 32'h0);
        egit(32'h104, KOSUL, 1'b0, 32'h0);
        egit(32'h10C, KOSUL, 1'b0, 32'h0);
        egit(32'h11C, KOSUL, 1'b0, 32'h0);
        egit(32'h13C, KOSUL, 1'b0, 32'h0);
        egit(32'h17C, KOSUL, 1'b1, 32'h80);
        // GHR is now 0x3C1; 0x1F8 maps onto 0x3BF. A JAL train installs a
        // BTB entry there without touching PHT or GHR.
        egit(32'h1F8, JAL, 1'b1, 32'h300);
        getir(32'h1F8, KOSUL);
        tahmin_kontrol("sat_low", 1'b0, 32'h1FC);
        getir(32'h1F8, JAL);
        tahmin_kontrol("sat_jal", 1'b1, 32'h300);

        // BTB alias: 0x40 and 0x140 share index 0x10 with different tags.
        egit(32'h40, JAL, 1'b1, 32'h400);
        getir(32'h40, JAL);
        tahmin_kontrol("alias_first", 1'b1, 32'h400);
        egit(32'h140, JAL, 1'b1, 32'h500);
        getir(32'h40, JAL);
        tahmin_kontrol("alias_evicted", 1'b0, 32'h44);
        getir(32'h140, JAL);
        tahmin_kontrol("alias_new", 1'b1, 32'h500);
        getir(32'h140, NOP);
        tahmin_kontrol("nonbranch", 1'b0, 32'h144);
        getir(32'h140, JAL);
        getir_gecerli = 1'b0;
        #1;
        tahmin_kontrol("fetch_invalid", 1'b0, 32'h144);

        // Same-cycle fetch and train: update visible only after the edge.
        @(negedge clk);
        getir_ps = 32'h300; getir_buyruk = JAL; getir_gecerli = 1'b1;
        yurut_ps = 32'h300; yurut_buyruk = JAL; yurut_dallan = 1'b1;
        yurut_dallan_ps = 32'h600; yurut_gecerli = 1'b1;
        #1;
        tahmin_kontrol("same_pre", 1'b0, 32'h304);
        @(posedge clk);
        #1;
        yurut_gecerli = 1'b0;
        tahmin_kontrol("same_post", 1'b1, 32'h600);

        // Alternating history at 0x200: 16 warm-up trains, then 8 checked.
        for (int i = 0; i < 24; i++) begin
            out = (i % 2 == 0);
            if (i >= 16) begin
                getir(32'h200, KOSUL);
                tahmin_kontrol("hist", out, out ? 32'h280 : 32'h204);
            end
            egit(32'h200, KOSUL, out, 32'h280);
        end

        // Mid-run reset, then a reset in the middle of the next sweep.
        getir_ps = 32'h140; getir_buyruk = JAL; getir_gecerli = 1'b1;
        @(negedge clk) rst = 1'b0;
        #1;
        chk("run_rst_hazir", 32'(hazir), 32'd0);
        tahmin_kontrol("run_rst_gate", 1'b0, 32'h144);
        @(negedge clk) rst = 1'b1;
        for (int c = 1; c <= 500; c++) begin
            @(posedge clk);
            #1;
            if (c == 5) tahmin_kontrol("sweep_gate_btb", 1'b0, 32'h144);
        end
        rst = 1'b0;
        #1;
        chk("mid_rst_hazir", 32'(hazir), 32'd0);
`ifdef GSHARE_ISTATISTIK_EN
        chk("mid_rst_toplam", istat_toplam, 32'd0);
        chk("mid_rst_yanlis", istat_yanlis, 32'd0);
`endif
        @(negedge clk) rst = 1'b1;
        hazir_bekle(n);
        chk("mid_sweep_len", 32'(n), 32'd1024);
        getir(32'h140, JAL);
        tahmin_kontrol("btb_cleared", 1'b0, 32'h144);
        getir(32'h300, JAL);
        tahmin_kontrol("btb_cleared2", 1'b0, 32'h304);

`ifdef GSHARE_ISTATISTIK_EN
        chk("stat_zero_toplam", istat_toplam, 32'd0);
        chk("stat_zero_yanlis", istat_yanlis, 32'd0);
        egit(32'h40, JAL, 1'b1, 32'h400);     // cold: mispredicted
        chk("stat1_toplam", istat_toplam, 32'd1);
        chk("stat1_yanlis", istat_yanlis, 32'd1);
        egit(32'h40, JAL, 1'b1, 32'h400);     // hit, same target: correct
        chk("stat2_toplam", istat_toplam, 32'd2);
        chk("stat2_yanlis", istat_yanlis, 32'd1);
        egit(32'h40, NOP, 1'b1, 32'h0);       // not a branch: ignored
        chk("stat3_toplam", istat_toplam, 32'd2);
        egit(32'h500, KOSUL, 1'b0, 32'h0);    // weak not-taken, correct
        chk("stat4_toplam", istat_toplam, 32'd3);
        chk("stat4_yanlis", istat_yanlis, 32'd1);
        egit(32'h40, JAL, 1'b1, 32'h480);     // hit, wrong target
        chk("stat5_toplam", istat_toplam, 32'd4);
        chk("stat5_yanlis", istat_yanlis, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
